water_level_tracker: RTL

Sequential, parametrised successor to the combinational water-level encoder for the water-supply subsystem.
- Synchronises N bottom-up level probes and validates that the pattern is thermometer-shaped.
- Debounces the pattern and publishes a held, encoded level for the display decoder.
- Adds change/trend pulses and sensor-fault detection.
- With LEVELS=3 the encoding matches the existing 2-bit display mapping: 0 Critical, 1 Low, 2 Mid, 3 High.

---
 rtl/water_pkg.sv | 18 +
 rtl/water_thermo_decode.sv | 31 +++
 rtl/water_level_tracker.sv | 126 ++++++++++++
 3 files changed

// File: rtl/water_pkg.sv
// Shared definitions for the water-level tracker: display level codes and
// the debounce/validation FSM state encoding.
package water_pkg;

  // Display level codes for the 3-probe tank (2-bit display mapping)
  localparam int LVL_CRITICAL = 0;
  localparam int LVL_LOW      = 1;
  localparam int LVL_MID      = 2;
  localparam int LVL_HIGH     = 3;

  // Tracker FSM states
  typedef enum logic [1:0] {
    ST_SETTLING = 2'd0,
    ST_STABLE   = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

endpackage

// File: rtl/water_thermo_decode.sv
// Thermometer decoder: counts the wet probes from the bottom up and flags
// patterns that are not of the form 0..01..1 (a wet probe above a dry one).
module water_thermo_decode #(
  parameter int LEVELS = 3,
  parameter int LVL_W  = $clog2(LEVELS + 1)
) (
  input  logic [LEVELS-1:0] pattern,
  output logic [LVL_W-1:0]  code,
  output logic              valid
);

  logic seen_dry;

  // Walk upward; any wet probe found above a dry one breaks the thermometer shape
  always_comb begin
    code     = '0;
    valid    = 1'b1;
    seen_dry = 1'b0;
    for (int i = 0; i < LEVELS; i++) begin
      if (pattern[i]) begin
        if (seen_dry) begin
          valid = 1'b0;
        end
        code = code + LVL_W'(1);
      end else begin
        seen_dry = 1'b1;
      end
    end
  end

endmodule

// File: rtl/water_level_tracker.sv
// Water-level tracker: synchronises the probe inputs, debounces the pattern,
// validates its thermometer shape and publishes a held level with change,
// trend and fault indications.
// Optional feature macro: WATER_CRITICAL_ALARM_EN adds the hysteretic
// critical_alarm output (set at level 0, cleared at ALARM_CLEAR_LEVEL or above).
module water_level_tracker
  import water_pkg::*;
#(
  parameter int LEVELS        = 3,
  parameter int STABLE_CYCLES = 4,
  parameter int LVL_W         = $clog2(LEVELS + 1)
`ifdef WATER_CRITICAL_ALARM_EN
  ,
  parameter int ALARM_CLEAR_LEVEL = 2
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LEVELS-1:0] probes,
  output logic [LVL_W-1:0]  level,
  output logic              level_valid,
  output logic              level_changed,
  output logic              rising,
  output logic              falling,
`ifdef WATER_CRITICAL_ALARM_EN
  output logic              critical_alarm,
`endif
  output logic              fault
);

  // Debounce counter saturates at STABLE_CYCLES, which never exceeds 255
  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [LEVELS-1:0] sync1;
  logic [LEVELS-1:0] sample;
  logic [LEVELS-1:0] cand;
  logic [7:0]        cnt;
  logic [LVL_W-1:0]  code;
  logic              code_valid;
  logic              same;
  logic              accept;
  state_t            state;

  water_thermo_decode #(
    .LEVELS(LEVELS),
    .LVL_W (LVL_W)
  ) u_decode (
    .pattern(sample),
    .code   (code),
    .valid  (code_valid)
  );

  // Two-flop synchroniser for the asynchronous probe inputs
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= '0;
      sample <= '0;
    end else begin
      sync1  <= probes;
      sample <= sync1;
    end
  end

  // Acceptance fires on the edge where the run of identical samples reaches STABLE_CYCLES
  always_comb begin
    same   = (sample == cand);
    accept = same ? (cnt == STABLE_N - 8'd1) : (STABLE_N == 8'd1);
  end

  // Candidate register and saturating run counter
  always_ff @(posedge clock) begin
    if (reset) begin
      cand <= '0;
      cnt  <= '0;
    end else if (!same) begin
      cand <= sample;
      cnt  <= 8'd1;
    end else if (cnt != STABLE_N) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Tracker FSM with registered level, pulse, fault and alarm outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_SETTLING;
      level         <= LVL_W'(LVL_CRITICAL);
      level_valid   <= 1'b0;
      level_changed <= 1'b0;
      rising        <= 1'b0;
      falling       <= 1'b0;
      fault         <= 1'b0;
`ifdef WATER_CRITICAL_ALARM_EN
      critical_alarm <= 1'b0;
`endif
    end else begin
      level_changed <= 1'b0;
      rising        <= 1'b0;
      falling       <= 1'b0;
      if (accept) begin
        if (code_valid) begin
          level_changed <= !level_valid || (code != level);
          rising        <= code > level;
          falling       <= level_valid && (code < level);
          level         <= code;
          level_valid   <= 1'b1;
          fault         <= 1'b0;
          state         <= ST_STABLE;
`ifdef WATER_CRITICAL_ALARM_EN
          if (code == LVL_W'(LVL_CRITICAL)) begin
            critical_alarm <= 1'b1;
          end else if (int'(code) >= ALARM_CLEAR_LEVEL) begin
            critical_alarm <= 1'b0;
          end
`endif
        end else begin
          fault <= 1'b1;
          state <= ST_FAULT;
        end
      end else if (!same && state != ST_SETTLING) begin
        state <= ST_SETTLING;
      end
    end
  end

endmodule
